// File: rtl/serializer_pkg.sv
// Shared definitions for the byte serializer slice.
// Contents:
//   state_t               - frame FSM states, 3-bit encoding
//   DATA_W                - data bits per frame (fixed at 8)
//   DEFAULT_CLKS_PER_BIT  - default number of clocks per serial bit
//   frame_parity()        - parity bit for a byte, even by default, odd when
//                           the upstream flag is set
package serializer_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam int DATA_W               = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 4;

    // XOR of all data bits gives even parity; the flag flips it to odd.
    function automatic logic frame_parity(input logic [DATA_W-1:0] data,
                                          input logic              odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/byte_serializer_if.sv
// Upstream valid/ready handshake between the shift/load register unit and
// the byte serializer.
// Signals:
//   in_valid  upstream byte available
//   in_ready  serializer can accept a byte
//   in_data   byte from the register unit
//   in_flag   upstream status flag (selects odd parity when set)
// Modports:
//   master - upstream side (drives valid/data/flag)
//   slave  - serializer side (drives ready)
interface byte_serializer_if;

    logic                              in_valid;
    logic                              in_ready;
    logic [serializer_pkg::DATA_W-1:0] in_data;
    logic                              in_flag;

    modport master (
        output in_valid,
        output in_data,
        output in_flag,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_flag,
        output in_ready
    );

endinterface

// File: rtl/bit_timer.sv
// Bit-period timer for the byte serializer.
// Ports:
//   n0     clock, rising edge
//   rst    asynchronous active-high reset
//   clear  reload the count to 0 on the next edge
//   count  current position inside the bit period, 0..CLKS_PER_BIT-1
//   tick   high on the last cycle of a bit period
module bit_timer #(
    parameter int CLKS_PER_BIT = serializer_pkg::DEFAULT_CLKS_PER_BIT
) (
    input  logic       n0,
    input  logic       rst,
    input  logic       clear,
    output logic [7:0] count,
    output logic       tick
);

    localparam logic [7:0] CNT_LAST = 8'(CLKS_PER_BIT - 1);

    always_ff @(posedge n0 or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else begin
            count <= count + 8'd1;
        end
    end

    assign tick = (count == CNT_LAST);

endmodule

// File: rtl/byte_serializer.sv
// Byte serializer: takes a byte plus status flag from the register unit over
// a valid/ready handshake and sends it as an asynchronous serial frame:
// start bit (0), 8 data bits LSB first, optional parity bit, 1 or 2 stop bits.
// Ports:
//   n0         clock, rising edge
//   rst        asynchronous active-high reset
//   up         upstream handshake (slave side)
//   tx         serial line, idles high
//   busy       frame in progress
//   done       one-cycle pulse on the last cycle of the final stop period
//   frame_cnt  completed-frame counter, wraps at 256
module byte_serializer
    import serializer_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int PARITY_EN    = 1,
    parameter int STOP_BITS    = 1
) (
    input  logic                n0,
    input  logic                rst,
    byte_serializer_if.slave    up,
    output logic                tx,
    output logic                busy,
    output logic                done,
    output logic [7:0]          frame_cnt
);

    localparam logic [7:0] CNT_LAST  = 8'(CLKS_PER_BIT - 1);
    localparam logic       STOP_LAST = 1'(STOP_BITS - 1);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic                par_q, par_d;
    logic [2:0]          bit_idx_q, bit_idx_d;
    logic                stop_idx_q, stop_idx_d;
    logic [7:0]          frame_cnt_d;
    logic                tx_d, busy_d, done_d;

    logic                clear;
    logic                tick;
    logic [7:0]          count;
    logic [7:0]          count_d;

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .n0    (n0),
        .rst   (rst),
        .clear (clear),
        .count (count),
        .tick  (tick)
    );

    assign up.in_ready = (state_q == IDLE);

    // All state, including the registered outputs, updates together so that
    // tx/busy/done are glitch-free flops.
    always_ff @(posedge n0 or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            par_q      <= 1'b0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            frame_cnt  <= '0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            par_q      <= par_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            frame_cnt  <= frame_cnt_d;
            tx         <= tx_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

    // Next-state logic. Every busy state changes (state or bit) on a timer
    // tick, so the timer is cleared on each tick and held clear in IDLE.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        par_d       = par_q;
        bit_idx_d   = bit_idx_q;
        stop_idx_d  = stop_idx_q;
        frame_cnt_d = frame_cnt;
        clear       = tick;

        case (state_q)
            IDLE: begin
                clear = 1'b1;
                if (up.in_valid) begin
                    shreg_d    = up.in_data;
                    par_d      = frame_parity(up.in_data, up.in_flag);
                    bit_idx_d  = '0;
                    stop_idx_d = 1'b0;
                    state_d    = START;
                end
            end
            START: begin
                if (tick) begin
                    bit_idx_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_idx_q == 3'd7) begin
                        stop_idx_d = 1'b0;
                        state_d    = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        shreg_d   = shreg_q >> 1;
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    stop_idx_d = 1'b0;
                    state_d    = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    if (stop_idx_q == STOP_LAST) begin
                        frame_cnt_d = frame_cnt + 8'd1;
                        state_d     = IDLE;
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered outputs are computed from the next state so they line up
    // with the cycle they describe. done looks ahead one cycle: it is set on
    // the edge that enters the final cycle of the last stop period.
    always_comb begin
        count_d = clear ? 8'd0 : (count + 8'd1);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == STOP) && (stop_idx_d == STOP_LAST) &&
                  (count_d == CNT_LAST);
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
            PARITY:  tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_byte_serializer.sv
// Self-checking bench for byte_serializer. Two instances: dut_a with default
// parameters (4 clocks/bit, parity, 1 stop bit) and dut_b with 1 clock/bit,
// no parity and 2 stop bits. Expected serial streams come from a frame model
// that lists the frame bits and stretches each over the bit period.
module tb_byte_serializer;

    logic n0 = 1'b0;
    logic rst;

    always #5 n0 = ~n0;

    byte_serializer_if ifa();
    byte_serializer_if ifb();

    logic       txa, busya, donea;
    logic [7:0] cnta;
    logic       txb, busyb, doneb;
    logic [7:0] cntb;

    byte_serializer #(
        .CLKS_PER_BIT(4),
        .PARITY_EN   (1),
        .STOP_BITS   (1)
    ) dut_a (
        .n0        (n0),
        .rst       (rst),
        .up        (ifa.slave),
        .tx        (txa),
        .busy      (busya),
        .done      (donea),
        .frame_cnt (cnta)
    );

    byte_serializer #(
        .CLKS_PER_BIT(1),
        .PARITY_EN   (0),
        .STOP_BITS   (2)
    ) dut_b (
        .n0        (n0),
        .rst       (rst),
        .up        (ifb.slave),
        .tx        (txb),
        .busy      (busyb),
        .done      (doneb),
        .frame_cnt (cntb)
    );

    typedef struct {
        logic [7:0] data;
        logic       flag;
        logic       par;
    } vec_t;

    vec_t vecs[8];
    int   total = 0;
    int   bad   = 0;
    int   exp_cnt[2];

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Frame model: bit list start, data LSB first, optional parity, stops;
    // each bit lasts cpb cycles. Vector index k holds cycle k+1 after accept.
    function automatic void buildFrame(input logic [7:0] d, input logic par,
                                       input int cpb, input int pen, input int sb,
                                       output logic [63:0] txs,
                                       output logic [63:0] dns, output int flen);
        bit bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (pen != 0) bits.push_back(par);
        for (int i = 0; i < sb; i++) bits.push_back(1'b1);
        txs  = '0;
        flen = 0;
        foreach (bits[i]) begin
            for (int j = 0; j < cpb; j++) begin
                txs[flen] = bits[i];
                flen++;
            end
        end
        dns = '0;
        dns[flen-1] = 1'b1;
    endfunction

    task automatic setInput(input int sel, input logic v, input logic [7:0] d,
                            input logic f);
        if (sel == 0) begin
            ifa.in_valid = v; ifa.in_data = d; ifa.in_flag = f;
        end else begin
            ifb.in_valid = v; ifb.in_data = d; ifb.in_flag = f;
        end
    endtask

    // Offer a byte, wait (bounded) for acceptance, then record tx/done/busy
    // for the flen cycles that follow the accepting edge.
    task automatic applyStimulus(input int sel, input logic [7:0] d, input logic f,
                                 input int flen, output logic [63:0] txs,
                                 output logic [63:0] dns, output logic [63:0] bs,
                                 output logic ok);
        int guard;
        guard = 0;
        txs = '0; dns = '0; bs = '0;
        @(negedge n0);
        setInput(sel, 1'b1, d, f);
        while ((((sel == 0) ? ifa.in_ready : ifb.in_ready) !== 1'b1) && guard < 200) begin
            @(negedge n0);
            guard++;
        end
        ok = (guard < 200);
        @(posedge n0);
        #1;
        setInput(sel, 1'b0, d, f);
        for (int k = 0; k < flen; k++) begin
            @(negedge n0);
            txs[k] = (sel == 0) ? txa : txb;
            dns[k] = (sel == 0) ? donea : doneb;
            bs[k]  = (sel == 0) ? busya : busyb;
        end
    endtask

    task automatic runChecked(input int sel, input logic [7:0] d, input logic f,
                              input logic par, input string tag);
        logic [63:0] etx, edn, atx, adn, abs;
        logic        ok;
        int          flen;
        if (sel == 0) buildFrame(d, par, 4, 1, 1, etx, edn, flen);
        else          buildFrame(d, par, 1, 0, 2, etx, edn, flen);
        applyStimulus(sel, d, f, flen, atx, adn, abs, ok);
        exp_cnt[sel] = (exp_cnt[sel] + 1) % 256;
        checkOutput({tag, "_accept"}, 64'(ok), 64'd1);
        checkOutput({tag, "_tx"}, atx, etx);
        checkOutput({tag, "_done"}, adn, edn);
        checkOutput({tag, "_busy"}, abs, (64'd1 << flen) - 64'd1);
        @(negedge n0);
        checkOutput({tag, "_idle_ready"}, 64'((sel == 0) ? ifa.in_ready : ifb.in_ready), 64'd1);
        checkOutput({tag, "_idle_busy"}, 64'((sel == 0) ? busya : busyb), 64'd0);
        checkOutput({tag, "_idle_tx"}, 64'((sel == 0) ? txa : txb), 64'd1);
        checkOutput({tag, "_frame_cnt"}, 64'((sel == 0) ? cnta : cntb), 64'(exp_cnt[sel]));
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        int          dones;
        int          ready_idx[$];
        logic [7:0]  d;
        logic        f;

        vecs[0] = '{8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'hA5, 1'b1, 1'b1};
        vecs[2] = '{8'h01, 1'b0, 1'b1};
        vecs[3] = '{8'h00, 1'b0, 1'b0};
        vecs[4] = '{8'hFF, 1'b1, 1'b1};
        vecs[5] = '{8'h3C, 1'b0, 1'b0};
        vecs[6] = '{8'h80, 1'b1, 1'b0};
        vecs[7] = '{8'h7F, 1'b0, 1'b1};
        exp_cnt[0] = 0;
        exp_cnt[1] = 0;

        rst = 1'b1;
        setInput(0, 1'b0, 8'h00, 1'b0);
        setInput(1, 1'b0, 8'h00, 1'b0);
        repeat (3) @(negedge n0);
        checkOutput("reset_tx", 64'(txa), 64'd1);
        checkOutput("reset_busy", 64'(busya), 64'd0);
        checkOutput("reset_done", 64'(donea), 64'd0);
        checkOutput("reset_ready", 64'(ifa.in_ready), 64'd1);
        checkOutput("reset_cnt", 64'(cnta), 64'd0);
        checkOutput("reset_b_tx", 64'(txb), 64'd1);
        rst = 1'b0;
        repeat (2) @(negedge n0);

        // Abort during DATA bit 3 (cycles 17..20 after the accept).
        @(negedge n0);
        setInput(0, 1'b1, 8'hFF, 1'b0);
        @(posedge n0);
        #1;
        setInput(0, 1'b0, 8'hFF, 1'b0);
        repeat (18) @(negedge n0);
        checkOutput("abort_pre_busy", 64'(busya), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("abort_tx", 64'(txa), 64'd1);
        checkOutput("abort_busy", 64'(busya), 64'd0);
        checkOutput("abort_ready", 64'(ifa.in_ready), 64'd1);
        checkOutput("abort_cnt", 64'(cnta), 64'd0);
        @(negedge n0);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge n0);
            if (donea) dones++;
        end
        checkOutput("abort_no_done", 64'(dones), 64'd0);
        checkOutput("abort_cnt_after", 64'(cnta), 64'd0);

        // Abort during START: tx must return high without waiting for an edge.
        @(negedge n0);
        setInput(0, 1'b1, 8'h00, 1'b0);
        @(posedge n0);
        #1;
        setInput(0, 1'b0, 8'h00, 1'b0);
        repeat (2) @(negedge n0);
        checkOutput("start_tx_low", 64'(txa), 64'd0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("start_abort_tx", 64'(txa), 64'd1);
        @(negedge n0);
        rst = 1'b0;
        @(negedge n0);

        for (int i = 0; i < 8; i++) begin
            runChecked(0, vecs[i].data, vecs[i].flag, vecs[i].par, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 16; i++) begin
            d = 8'($urandom_range(0, 255));
            f = 1'($urandom_range(0, 1));
            runChecked(0, d, f, 1'(($countones(d) + int'(f)) % 2), $sformatf("rnd_a%0d", i));
        end

        runChecked(1, 8'h01, 1'b0, 1'b0, "cfg_b_01");

        // in_valid held high: in_ready high exactly once between frames.
        @(negedge n0);
        setInput(0, 1'b1, 8'h3C, 1'b0);
        for (int i = 0; i < 135; i++) begin
            if (ifa.in_ready) begin
                ready_idx.push_back(i);
                checkOutput("hold_ready_not_busy", 64'(busya), 64'd0);
            end
            @(negedge n0);
        end
        setInput(0, 1'b0, 8'h3C, 1'b0);
        checkOutput("hold_ready_count", 64'(ready_idx.size()), 64'd3);
        if (ready_idx.size() == 3) begin
            checkOutput("hold_spacing1", 64'(ready_idx[1] - ready_idx[0]), 64'd45);
            checkOutput("hold_spacing2", 64'(ready_idx[2] - ready_idx[1]), 64'd45);
        end
        exp_cnt[0] = (exp_cnt[0] + 3) % 256;
        @(negedge n0);
        checkOutput("hold_cnt", 64'(cnta), 64'(exp_cnt[0]));

        for (int i = 0; i < 256; i++) begin
            d = 8'($urandom_range(0, 255));
            runChecked(1, d, 1'($urandom_range(0, 1)), 1'b0, $sformatf("wrap%0d", i));
        end
        checkOutput("wrap_final_cnt", 64'(cntb), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
